// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// State codes, adjust digit selects and BCD digit limits.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   localparam logic [1:0] SEL_SEC0 = 2'd0;
   localparam logic [1:0] SEL_SEC1 = 2'd1;
   localparam logic [1:0] SEL_MIN0 = 2'd2;
   localparam logic [1:0] SEL_MIN1 = 2'd3;

   localparam logic [3:0] MAX_ONES = 4'd9;
   localparam logic [3:0] MAX_TENS = 4'd5;

   // Wraps at the digit max; anything out of range also lands on 0.
   function automatic logic [3:0] bcd_inc(
      input logic [3:0] d,
      input logic [3:0] mx
   );
      return (d >= mx) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control inputs and digit/status outputs of the stopwatch controller.
// The master side drives buttons and adjust controls.
interface stopwatch_ctrl_if;
   logic       pause_p;
   logic       clear_p;
   logic       adj;
   logic [1:0] sel;
   logic [3:0] sec0;
   logic [2:0] sec1;
   logic [3:0] min0;
   logic [2:0] min1;
   logic       paused;
   logic       adj_active;

   modport master (
      output pause_p, clear_p, adj, sel,
      input  sec0, sec1, min0, min1, paused, adj_active
   );

   modport slave (
      input  pause_p, clear_p, adj, sel,
      output sec0, sec1, min0, min1, paused, adj_active
   );
endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Enable-gated modulo-DIV divider; tick marks the last count.
// Holds its count while en is low; clr returns it to 0.
module tick_gen #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] MAX = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == MAX) ? '0 : r_cnt + W'(1);
      end
   end

   assign tick = en & (r_cnt == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: run/pause/adjust FSM, BCD carry chain,
// and the run/adjust tick dividers.
module stopwatch_ctrl #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned RUN_HZ = 1,
   parameter int unsigned ADJ_HZ = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   stopwatch_ctrl_if.slave  bus
);
   import stopwatch_ctrl_pkg::*;

   state_t     r_state;
   state_t     w_nxt_state;
   state_t     r_ret;
   state_t     w_nxt_ret;
   logic       r_paused;
   logic       r_adj_active;
   logic       w_paused_d;
   logic       w_adj_active_d;
   logic       w_run_tick;
   logic       w_adj_tick;
   logic       w_adj_entry;
   logic [3:0] r_sec0;
   logic [2:0] r_sec1;
   logic [3:0] r_min0;
   logic [2:0] r_min1;
   logic       w_s0_wrap;
   logic       w_s1_wrap;
   logic       w_m0_wrap;

   assign w_adj_entry = (r_state != ST_ADJUST) & bus.adj;

   tick_gen #(.DIV(CLK_HZ / RUN_HZ)) u_run_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (r_state == ST_RUN),
      .clr   (bus.clear_p),
      .tick  (w_run_tick)
   );

   tick_gen #(.DIV(CLK_HZ / ADJ_HZ)) u_adj_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (r_state == ST_ADJUST),
      .clr   (w_adj_entry),
      .tick  (w_adj_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_ret        <= ST_RUN;
         r_paused     <= 1'b0;
         r_adj_active <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_ret        <= w_nxt_ret;
         r_paused     <= w_paused_d;
         r_adj_active <= w_adj_active_d;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ret   = r_ret;
      case (r_state)
         ST_RUN: begin
            if (bus.adj) begin
               w_nxt_state = ST_ADJUST;
               w_nxt_ret   = ST_RUN;
            end else if (bus.pause_p) begin
               w_nxt_state = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (bus.adj) begin
               w_nxt_state = ST_ADJUST;
               w_nxt_ret   = ST_PAUSED;
            end else if (bus.pause_p) begin
               w_nxt_state = ST_RUN;
            end
         end
         ST_ADJUST: begin
            // pause_p while adjusting only flips where we go back to
            if (!bus.adj) begin
               w_nxt_state = r_ret;
            end else if (bus.pause_p) begin
               w_nxt_ret = (r_ret == ST_RUN) ? ST_PAUSED : ST_RUN;
            end
         end
         default: begin
            w_nxt_state = ST_RUN;
            w_nxt_ret   = ST_RUN;
         end
      endcase
   end

   always_comb begin
      w_adj_active_d = (w_nxt_state == ST_ADJUST);
      w_paused_d     = (w_nxt_state == ST_PAUSED)
                     | (w_adj_active_d & (w_nxt_ret == ST_PAUSED));
   end

   assign w_s0_wrap = (r_sec0 >= MAX_ONES);
   assign w_s1_wrap = ({1'b0, r_sec1} >= MAX_TENS);
   assign w_m0_wrap = (r_min0 >= MAX_ONES);

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear_p) begin
         r_sec0 <= '0;
         r_sec1 <= '0;
         r_min0 <= '0;
         r_min1 <= '0;
      end else if (w_run_tick) begin
         r_sec0 <= bcd_inc(r_sec0, MAX_ONES);
         if (w_s0_wrap) begin
            r_sec1 <= 3'(bcd_inc({1'b0, r_sec1}, MAX_TENS));
            if (w_s1_wrap) begin
               r_min0 <= bcd_inc(r_min0, MAX_ONES);
               if (w_m0_wrap) begin
                  r_min1 <= 3'(bcd_inc({1'b0, r_min1}, MAX_TENS));
               end
            end
         end
      end else if (w_adj_tick) begin
         unique case (bus.sel)
            SEL_SEC0: r_sec0 <= bcd_inc(r_sec0, MAX_ONES);
            SEL_SEC1: r_sec1 <= 3'(bcd_inc({1'b0, r_sec1}, MAX_TENS));
            SEL_MIN0: r_min0 <= bcd_inc(r_min0, MAX_ONES);
            SEL_MIN1: r_min1 <= 3'(bcd_inc({1'b0, r_min1}, MAX_TENS));
         endcase
      end
   end

   assign bus.sec0       = r_sec0;
   assign bus.sec1       = r_sec1;
   assign bus.min0       = r_min0;
   assign bus.min1       = r_min1;
   assign bus.paused     = r_paused;
   assign bus.adj_active = r_adj_active;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at CLK_HZ=20: vector table, corner
// sequences and random stimulus against a seconds-count model.
module tb_stopwatch_ctrl;

   localparam int RUN_DIV = 20;
   localparam int ADJ_DIV = 10;
   localparam int M_RUN   = 0;
   localparam int M_PAUSE = 1;
   localparam int M_ADJ   = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(
      .CLK_HZ (20),
      .RUN_HZ (1),
      .ADJ_HZ (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: elapsed time as plain seconds 0..3599, plus state and phases.
   int m_t = 0;
   int m_st = M_RUN;
   int m_ret = M_RUN;
   int m_rc = 0;
   int m_ac = 0;

   typedef struct {
      bit       rn;
      bit       p;
      bit       c;
      bit       a;
      bit [1:0] s;
      int       disp;
      bit       ep;
      bit       ea;
   } vec_t;

   vec_t tbl[9];

   function automatic int bump(input int t, input int s);
      int d0, d1, d2, d3;
      d0 = t % 10;
      d1 = (t / 10) % 6;
      d2 = (t / 60) % 10;
      d3 = t / 600;
      case (s)
         0: d0 = (d0 + 1) % 10;
         1: d1 = (d1 + 1) % 6;
         2: d2 = (d2 + 1) % 10;
         default: d3 = (d3 + 1) % 6;
      endcase
      return d3 * 600 + d2 * 60 + d1 * 10 + d0;
   endfunction

   function automatic int m_disp();
      return (m_t / 600) * 1000 + ((m_t / 60) % 10) * 100
           + ((m_t / 10) % 6) * 10 + (m_t % 10);
   endfunction

   function automatic int m_flags();
      int pz;
      pz = ((m_st == M_PAUSE) || (m_st == M_ADJ && m_ret == M_PAUSE)) ? 1 : 0;
      return pz * 2 + ((m_st == M_ADJ) ? 1 : 0);
   endfunction

   function automatic int dut_disp();
      return int'(bus.min1) * 1000 + int'(bus.min0) * 100
           + int'(bus.sec1) * 10 + int'(bus.sec0);
   endfunction

   function automatic int dut_flags();
      return int'(bus.paused) * 2 + int'(bus.adj_active);
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_update(input bit rn, input bit p, input bit c,
                           input bit a, input bit [1:0] s);
      int  ost;
      bit  rt;
      bit  at;
      if (!rn) begin
         m_t = 0; m_st = M_RUN; m_ret = M_RUN; m_rc = 0; m_ac = 0;
         return;
      end
      ost = m_st;
      rt = (ost == M_RUN) && (m_rc == RUN_DIV - 1);
      at = (ost == M_ADJ) && (m_ac == ADJ_DIV - 1);
      if (c) m_t = 0;
      else if (rt) m_t = (m_t + 1) % 3600;
      else if (at) m_t = bump(m_t, int'(s));
      if (c) m_rc = 0;
      else if (ost == M_RUN) m_rc = (m_rc + 1) % RUN_DIV;
      if (ost != M_ADJ && a) m_ac = 0;
      else if (ost == M_ADJ) m_ac = (m_ac + 1) % ADJ_DIV;
      if (ost == M_ADJ) begin
         if (!a) m_st = m_ret;
         else if (p) m_ret = (m_ret == M_RUN) ? M_PAUSE : M_RUN;
      end else if (a) begin
         m_ret = ost;
         m_st = M_ADJ;
      end else if (p) begin
         m_st = (ost == M_RUN) ? M_PAUSE : M_RUN;
      end
   endtask

   task automatic step(input bit rn, input bit p, input bit c,
                       input bit a, input bit [1:0] s);
      rst_n       = rn;
      bus.pause_p = p;
      bus.clear_p = c;
      bus.adj     = a;
      bus.sel     = s;
      @(posedge clk);
      m_update(rn, p, c, a, s);
      #1;
      check("model_digits", dut_disp(), m_disp());
      check("model_flags", dut_flags(), m_flags());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 2'd0);
   endtask

   initial begin
      int  d;
      bit  got0;
      bit  a_lvl;
      bit [1:0] sv;

      tbl[0] = '{0, 0, 0, 0, 2'd0, 0, 0, 0};
      tbl[1] = '{1, 1, 0, 0, 2'd0, 0, 1, 0};
      tbl[2] = '{1, 1, 0, 0, 2'd0, 0, 0, 0};
      tbl[3] = '{1, 0, 0, 1, 2'd0, 0, 0, 1};
      tbl[4] = '{1, 1, 0, 1, 2'd0, 0, 1, 1};
      tbl[5] = '{1, 0, 0, 0, 2'd0, 0, 1, 0};
      tbl[6] = '{1, 1, 1, 0, 2'd0, 0, 0, 0};
      tbl[7] = '{1, 0, 1, 1, 2'd2, 0, 0, 1};
      tbl[8] = '{0, 0, 0, 1, 2'd0, 0, 0, 0};

      rst_n = 1'b0;
      bus.pause_p = 1'b0;
      bus.clear_p = 1'b0;
      bus.adj = 1'b0;
      bus.sel = 2'd0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].rn, tbl[i].p, tbl[i].c, tbl[i].a, tbl[i].s);
         check($sformatf("tbl%0d_digits", i), dut_disp(), tbl[i].disp);
         check($sformatf("tbl%0d_paused", i), int'(bus.paused), int'(tbl[i].ep));
         check($sformatf("tbl%0d_adj", i), int'(bus.adj_active), int'(tbl[i].ea));
      end

      // 1: free run to the minute carry
      step(0, 0, 0, 0, 2'd0);
      idle(1180);
      check("run_0059", dut_disp(), 59);
      idle(19);
      check("run_0059_hold", dut_disp(), 59);
      idle(1);
      check("run_0100", dut_disp(), 100);

      // 2: preload 59:59 then wrap
      step(0, 0, 0, 0, 2'd0);
      for (int k = 0; k <= 280; k++) begin
         sv = (k <= 90) ? 2'd0 : (k <= 140) ? 2'd1 : (k <= 230) ? 2'd2 : 2'd3;
         step(1, 0, 0, 1, sv);
      end
      check("preload_5959", dut_disp(), 5959);
      step(1, 0, 0, 0, 2'd0);
      got0 = 1'b0;
      for (int k = 0; k < 25 && !got0; k++) begin
         step(1, 0, 0, 0, 2'd0);
         d = dut_disp();
         check("wrap_no_glitch", int'(d == 5959 || d == 0), 1);
         got0 = (d == 0);
      end
      check("wrap_0000", dut_disp(), 0);

      // 3: pause holds digits and divider phase
      step(0, 0, 0, 0, 2'd0);
      idle(25);
      check("pre_pause", dut_disp(), 1);
      step(1, 1, 0, 0, 2'd0);
      check("paused_set", int'(bus.paused), 1);
      idle(100);
      check("paused_frozen", dut_disp(), 1);
      check("paused_still", int'(bus.paused), 1);
      step(1, 1, 0, 0, 2'd0);
      check("resume", int'(bus.paused), 0);
      idle(13);
      check("resume_remaining_hold", dut_disp(), 1);
      idle(1);
      check("resume_remaining_tick", dut_disp(), 2);

      // 4: adjust sec1 for 7 ticks
      step(0, 0, 0, 0, 2'd0);
      step(1, 0, 0, 1, 2'd1);
      for (int k = 0; k < 70; k++) step(1, 0, 0, 1, 2'd1);
      check("adj_sec1", dut_disp(), 10);
      check("adj_active", int'(bus.adj_active), 1);
      step(1, 0, 0, 0, 2'd1);
      check("adj_exit", dut_flags(), 0);

      // 5: run_tick with pause_p, then clear with pause_p
      step(0, 0, 0, 0, 2'd0);
      idle(19);
      step(1, 1, 0, 0, 2'd0);
      check("tick_pause_digits", dut_disp(), 1);
      check("tick_pause_flag", int'(bus.paused), 1);
      step(1, 1, 1, 0, 2'd0);
      check("clear_pause_digits", dut_disp(), 0);
      check("clear_pause_flag", int'(bus.paused), 0);

      // 6: reset while adjusting at 12:34
      step(0, 0, 0, 0, 2'd0);
      for (int k = 0; k <= 100; k++) begin
         sv = (k <= 10) ? 2'd3 : (k <= 30) ? 2'd2 : (k <= 60) ? 2'd1 : 2'd0;
         step(1, 0, 0, 1, sv);
      end
      check("preload_1234", dut_disp(), 1234);
      step(0, 0, 0, 1, 2'd0);
      check("rst_digits", dut_disp(), 0);
      check("rst_flags", dut_flags(), 0);
      step(1, 0, 0, 1, 2'd0);
      check("rst_reenter", int'(bus.adj_active), 1);

      // random traffic against the model
      step(0, 0, 0, 0, 2'd0);
      a_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) a_lvl = ~a_lvl;
         step($urandom_range(499) != 0, $urandom_range(15) == 0,
              $urandom_range(63) == 0, a_lvl, 2'($urandom_range(3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
